blink_pattern_monitor: RTL and testbench

Receive-side checker for the blinking-light output. Samples a `light` waveform, measures each ON and OFF run length in clock cycles, and counts completed blink periods. It flags runs outside the expected duration window and lights that are stuck. It sits beside blinking_light_top in system benches and on-chip self-test, driven by that block's `light` output.

---
 rtl/blink_mon_pkg.sv | 25 ++
 rtl/light_edge_sync.sv | 26 ++
 rtl/blink_pattern_monitor.sv | 139 +++++++++++++
 tb/tb_blink_pattern_monitor.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_mon_pkg.sv
// rtl/blink_mon_pkg.sv - shared state type, default blink timing and run-window check
package blink_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_ON    = 3'd2,
    ST_OFF   = 3'd3,
    ST_STUCK = 3'd4
  } mon_state_t;

  localparam int DEF_EXP_ON  = 4;
  localparam int DEF_EXP_OFF = 4;
  localparam int DEF_TOL     = 1;

  // Lower bound clamps at 1; wide unsigned math keeps exp_len+tol from wrapping.
  function automatic logic in_window(input logic [31:0] len,
                                     input logic [31:0] exp_len,
                                     input logic [31:0] tol);
    logic [31:0] lo;
    lo = (exp_len > tol) ? (exp_len - tol) : 32'd1;
    return (len >= lo) && (len <= (exp_len + tol));
  endfunction

endpackage

// File: rtl/light_edge_sync.sv
// rtl/light_edge_sync.sv - registers the light input and flags rising/falling samples
module light_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic light,
  output logic rise,
  output logic fall
);

  logic light_s;
  logic light_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      light_s <= 1'b0;
      light_d <= 1'b0;
    end else begin
      light_s <= light;
      light_d <= light_s;
    end
  end

  assign rise = light_s & ~light_d;
  assign fall = ~light_s & light_d;

endmodule

// File: rtl/blink_pattern_monitor.sv
// rtl/blink_pattern_monitor.sv - measures ON/OFF run lengths of a blinking light and flags bad or stuck runs
module blink_pattern_monitor
  import blink_mon_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int EXP_ON  = DEF_EXP_ON,
  parameter int EXP_OFF = DEF_EXP_OFF,
  parameter int TOL     = DEF_TOL,
  parameter int BLINK_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               light,
  input  logic               clr_err,
  output logic [CNT_W-1:0]   on_len,
  output logic [CNT_W-1:0]   off_len,
  output logic               period_valid,
  output logic [BLINK_W-1:0] blink_count,
  output logic               len_err,
  output logic               stuck_err,
  output logic [2:0]         state_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mon_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rise, fall;
  logic             cap_on, cap_off, win_bad, sat;

  light_edge_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .light (light),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap_on    = 1'b0;
    cap_off   = 1'b0;
    win_bad   = 1'b0;
    sat       = 1'b0;
    if (!en) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_SYNC;
          cnt_nxt   = '0;
        end
        ST_SYNC: begin
          if (rise) begin
            state_nxt = ST_ON;
            cnt_nxt   = CNT_ONE;
          end
        end
        ST_ON: begin
          if (fall) begin
            cap_on    = 1'b1;
            win_bad   = !in_window(32'(cnt), 32'(EXP_ON), 32'(TOL));
            cnt_nxt   = CNT_ONE;
            state_nxt = ST_OFF;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
            if (cnt_nxt == CNT_MAX) begin
              sat       = 1'b1;
              state_nxt = ST_STUCK;
            end
          end
        end
        ST_OFF: begin
          if (rise) begin
            cap_off   = 1'b1;
            win_bad   = !in_window(32'(cnt), 32'(EXP_OFF), 32'(TOL));
            cnt_nxt   = CNT_ONE;
            state_nxt = ST_ON;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
            if (cnt_nxt == CNT_MAX) begin
              sat       = 1'b1;
              state_nxt = ST_STUCK;
            end
          end
        end
        ST_STUCK: begin
          // Counter stays pinned at saturation until the light moves again.
          if (rise) begin
            state_nxt = ST_ON;
            cnt_nxt   = CNT_ONE;
          end else if (fall) begin
            state_nxt = ST_OFF;
            cnt_nxt   = CNT_ONE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      on_len       <= '0;
      off_len      <= '0;
      period_valid <= 1'b0;
      blink_count  <= '0;
      len_err      <= 1'b0;
      stuck_err    <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      period_valid <= cap_off;
      if (cap_on) on_len <= cnt;
      if (cap_off) begin
        off_len     <= cnt;
        blink_count <= blink_count + BLINK_W'(1);
      end
      // A fresh detection in the clearing cycle keeps the flag set.
      len_err   <= win_bad | (len_err & ~clr_err);
      stuck_err <= sat | (stuck_err & ~clr_err);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_blink_pattern_monitor.sv
// tb/tb_blink_pattern_monitor.sv - randomized and directed checks of blink_pattern_monitor against a run-length model
module tb_blink_pattern_monitor;
  import blink_mon_pkg::*;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_MEAS  = 2;
  localparam int M_STUCK = 3;

  logic clk = 1'b0;
  logic reset, en, light, clr_err;

  logic [7:0]  on_len_a  [2];
  logic [7:0]  off_len_a [2];
  logic        pv_a      [2];
  logic [15:0] bc_a      [2];
  logic        le_a      [2];
  logic        se_a      [2];
  logic [2:0]  st_a      [2];
  logic [37:0] obs       [2];

  int total = 0;
  int bad   = 0;

  int          m_mode [2];
  int          m_run  [2];
  bit          m_lvl  [2];
  bit          m_pv   [2];
  bit          m_le   [2];
  bit          m_se   [2];
  logic [7:0]  m_on   [2];
  logic [7:0]  m_off  [2];
  logic [15:0] m_bc   [2];
  bit          m_ls, m_ld;
  int          m_exp_on  [2] = '{4, 1};
  int          m_exp_off [2] = '{4, 1};
  int          m_tol     [2] = '{1, 0};

  always #5 clk = ~clk;

  blink_pattern_monitor u0 (
    .clk(clk), .reset(reset), .en(en), .light(light), .clr_err(clr_err),
    .on_len(on_len_a[0]), .off_len(off_len_a[0]), .period_valid(pv_a[0]),
    .blink_count(bc_a[0]), .len_err(le_a[0]), .stuck_err(se_a[0]), .state_o(st_a[0])
  );

  blink_pattern_monitor #(.EXP_ON(1), .EXP_OFF(1), .TOL(0)) u1 (
    .clk(clk), .reset(reset), .en(en), .light(light), .clr_err(clr_err),
    .on_len(on_len_a[1]), .off_len(off_len_a[1]), .period_valid(pv_a[1]),
    .blink_count(bc_a[1]), .len_err(le_a[1]), .stuck_err(se_a[1]), .state_o(st_a[1])
  );

  assign obs[0] = {st_a[0], pv_a[0], bc_a[0], on_len_a[0], off_len_a[0], le_a[0], se_a[0]};
  assign obs[1] = {st_a[1], pv_a[1], bc_a[1], on_len_a[1], off_len_a[1], le_a[1], se_a[1]};

  function automatic bit win_ok(input int run, input int e, input int t);
    int lo;
    lo = (e - t < 1) ? 1 : e - t;
    return (run >= lo) && (run <= e + t);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE; m_run[i] = 0; m_lvl[i] = 0; m_pv[i] = 0;
      m_le[i] = 0; m_se[i] = 0; m_on[i] = '0; m_off[i] = '0; m_bc[i] = '0;
    end
    m_ls = 0; m_ld = 0;
  endfunction

  // Advances the run-length model by one clock using the inputs present at the edge.
  function automatic void model_step();
    bit rise, fall, set_len, set_stk;
    if (reset) begin
      model_reset();
      return;
    end
    rise = m_ls & !m_ld;
    fall = !m_ls & m_ld;
    for (int i = 0; i < 2; i++) begin
      set_len = 0; set_stk = 0; m_pv[i] = 0;
      if (!en) m_mode[i] = M_IDLE;
      else case (m_mode[i])
        M_IDLE: m_mode[i] = M_WAIT;
        M_WAIT: if (rise) begin m_mode[i] = M_MEAS; m_lvl[i] = 1; m_run[i] = 1; end
        M_MEAS: begin
          if (rise || fall) begin
            if (fall) begin
              m_on[i] = 8'(m_run[i]);
              set_len = !win_ok(m_run[i], m_exp_on[i], m_tol[i]);
            end else begin
              m_off[i] = 8'(m_run[i]);
              m_pv[i]  = 1;
              m_bc[i]  = m_bc[i] + 16'd1;
              set_len  = !win_ok(m_run[i], m_exp_off[i], m_tol[i]);
            end
            m_lvl[i] = rise;
            m_run[i] = 1;
          end else begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] >= 255) begin m_mode[i] = M_STUCK; set_stk = 1; end
          end
        end
        default: if (rise || fall) begin m_mode[i] = M_MEAS; m_lvl[i] = rise; m_run[i] = 1; end
      endcase
      m_le[i] = set_len | (m_le[i] & !clr_err);
      m_se[i] = set_stk | (m_se[i] & !clr_err);
    end
    m_ld = m_ls;
    m_ls = light;
  endfunction

  function automatic logic [37:0] expv(input int i);
    logic [2:0] st;
    case (m_mode[i])
      M_IDLE:  st = ST_IDLE;
      M_WAIT:  st = ST_SYNC;
      M_MEAS:  st = m_lvl[i] ? ST_ON : ST_OFF;
      default: st = ST_STUCK;
    endcase
    return {st, m_pv[i], m_bc[i], m_on[i], m_off[i], m_le[i], m_se[i]};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) tick();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== 38'd0) begin
        bad++; $display("FAIL reset_state u%0d got %h want 0", i, obs[i]);
      end
    end
    reset = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== expv(i)) begin
        bad++; $display("FAIL reset_release u%0d got %h want %h", i, obs[i], expv(i));
      end
    end
  endtask

  task automatic test_nominal();
    en = 1'b1;
    for (int c = 0; c < 64; c++) begin
      light = ((c % 8) < 4);
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== expv(i)) begin
          bad++; $display("FAIL nominal u%0d cyc %0d got %h want %h", i, c, obs[i], expv(i));
        end
      end
    end
    total++;
    if (on_len_a[0] !== 8'd4 || off_len_a[0] !== 8'd4 || le_a[0] !== 1'b0) begin
      bad++; $display("FAIL nominal_lens got on=%0d off=%0d err=%0d want 4 4 0",
                      on_len_a[0], off_len_a[0], le_a[0]);
    end
  endtask

  task automatic test_len_err();
    for (int c = 0; c < 60; c++) begin
      light   = ((c % 10) < 4);
      clr_err = (c == 25);
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== expv(i)) begin
          bad++; $display("FAIL len_err u%0d cyc %0d got %h want %h", i, c, obs[i], expv(i));
        end
      end
    end
    clr_err = 1'b0;
    total++;
    if (off_len_a[0] !== 8'd6 || le_a[0] !== 1'b1) begin
      bad++; $display("FAIL len_err_flag got off=%0d err=%0d want 6 1", off_len_a[0], le_a[0]);
    end
  endtask

  task automatic test_stuck();
    light = 1'b1;
    for (int c = 0; c < 300; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== expv(i)) begin
          bad++; $display("FAIL stuck u%0d cyc %0d got %h want %h", i, c, obs[i], expv(i));
        end
      end
    end
    total++;
    if (st_a[0] !== ST_STUCK || se_a[0] !== 1'b1) begin
      bad++; $display("FAIL stuck_state got st=%0d se=%0d want %0d 1", st_a[0], se_a[0], ST_STUCK);
    end
    light = 1'b0;
    tick();
    tick();
    total++;
    if (st_a[0] !== ST_OFF) begin
      bad++; $display("FAIL stuck_release got st=%0d want %0d", st_a[0], ST_OFF);
    end
  endtask

  task automatic test_enable_drop();
    light = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    light = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    en = 1'b0;
    tick();
    total++;
    if (st_a[0] !== ST_IDLE) begin
      bad++; $display("FAIL en_drop got st=%0d want %0d", st_a[0], ST_IDLE);
    end
    tick();
    tick();
    en = 1'b1;
    tick();
    total++;
    if (st_a[0] !== ST_SYNC) begin
      bad++; $display("FAIL en_resync got st=%0d want %0d", st_a[0], ST_SYNC);
    end
    for (int c = 0; c < 40; c++) begin
      light = ((c % 8) >= 4);
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== expv(i)) begin
          bad++; $display("FAIL en_after u%0d cyc %0d got %h want %h", i, c, obs[i], expv(i));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    light = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    light = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    #2 reset = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== 38'd0) begin
        bad++; $display("FAIL async_reset u%0d got %h want 0", i, obs[i]);
      end
    end
    reset = 1'b0;
    tick();
    tick();
    total++;
    if (st_a[0] !== ST_SYNC) begin
      bad++; $display("FAIL async_resync got st=%0d want %0d", st_a[0], ST_SYNC);
    end
  endtask

  task automatic test_fast_blink();
    int npv;
    npv = 0;
    en = 1'b0;
    tick();
    en = 1'b1;
    for (int c = 0; c < 50; c++) begin
      light   = (c % 2 == 0);
      clr_err = (c == 10);
      tick();
      if (c >= 30) npv += int'(pv_a[1]);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== expv(i)) begin
          bad++; $display("FAIL fast u%0d cyc %0d got %h want %h", i, c, obs[i], expv(i));
        end
      end
    end
    clr_err = 1'b0;
    total++;
    if (npv != 10 || le_a[1] !== 1'b0 || se_a[1] !== 1'b0 || on_len_a[1] !== 8'd1 || off_len_a[1] !== 8'd1) begin
      bad++; $display("FAIL fast_summary got pv=%0d le=%0d se=%0d on=%0d off=%0d want 10 0 0 1 1",
                      npv, le_a[1], se_a[1], on_len_a[1], off_len_a[1]);
    end
  endtask

  task automatic test_random();
    int left;
    left = 0;
    for (int c = 0; c < 600; c++) begin
      if (left == 0) begin
        light = ~light;
        left  = $urandom_range(1, 7);
      end
      left--;
      en      = en ? ($urandom_range(0, 59) != 0) : 1'b1;
      clr_err = ($urandom_range(0, 19) == 0);
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== expv(i)) begin
          bad++; $display("FAIL random u%0d cyc %0d got %h want %h", i, c, obs[i], expv(i));
        end
      end
    end
    clr_err = 1'b0;
    en = 1'b1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; light = 1'b0; clr_err = 1'b0;
    model_reset();
    test_reset();
    test_nominal();
    test_len_err();
    test_stuck();
    test_enable_drop();
    test_async_reset();
    test_fast_blink();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
